// File: rtl/rr_decoder_sequencer.sv
// ---------------------------------------------------------------------------
// rr_decoder_sequencer
//
// Round-robin arbiter that drives a 3-to-8 output decoder. While idle it
// samples the request vector. It grants one requester and holds the decoder
// select (idx) and enable until the consumer pulses done or the grant times
// out. After each grant the next search starts one position past the
// requester that was just served.
//
// Ports
//   clk      in   1     single clock, rising edge
//   rst      in   1     synchronous, active-high reset
//   req      in   N     level-sensitive request vector, bit i = requester i
//   done     in   1     single-cycle pulse: consumer finished with the grant
//   idx      out  IDXW  granted requester index (decoder select), registered
//   enable   out  1     grant active (decoder enable), registered
//   timeout  out  1     one-cycle pulse: grant released by timeout
// ---------------------------------------------------------------------------
module rr_decoder_sequencer #(
    parameter int N       = 8,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [IDXW-1:0] idx,
    output logic            enable,
    output logic            timeout
);

    // With TIMEOUT=0 the counter is unused, so it is kept one bit wide.
    localparam int CNTW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_enable;
    logic            r_timeout;
    logic [IDXW-1:0] r_ptr;
    logic [CNTW-1:0] r_cnt;

    // Rotate requests so that bit 0 is the position right after the last
    // winner. The first set bit of the rotated vector is the next winner.
    // N is a power of two, so the index addition wraps naturally.
    logic [N-1:0]    w_rot;
    logic [IDXW-1:0] w_off;
    logic [IDXW-1:0] w_winner;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign w_rot[gi] = req[r_ptr + IDXW'(gi + 1)];
    end

    // Scan from the top down so that the lowest set offset is the one kept.
    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDXW'(k);
            end
        end
    end

    assign w_winner = r_ptr + w_off + IDXW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_enable  <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= IDXW'(N - 1);
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_idx    <= w_winner;
                        r_enable <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (done) begin
                        // done has priority over a coincident timeout.
                        r_enable <= 1'b0;
                        r_ptr    <= r_idx;
                        r_state  <= S_IDLE;
                    end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
                        r_enable  <= 1'b0;
                        r_ptr     <= r_idx;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (r_cnt != '1) begin
                        // Saturate rather than wrap; this only matters when
                        // TIMEOUT=0 and the grant is held for a long time.
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign idx     = r_idx;
    assign enable  = r_enable;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_decoder_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rr_decoder_sequencer
//
// Self-checking bench for rr_decoder_sequencer (N=8, TIMEOUT=16). A
// cycle-level reference model tracks whether a grant is active, who holds it,
// how long it has been held, and who was served last. Every cycle the DUT
// outputs are compared with that model. Directed scenarios pin the model with
// literal expectations. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_rr_decoder_sequencer;

    localparam int N  = 8;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] idx;
    logic       enable;
    logic       timeout;

    rr_decoder_sequencer #(.N(N), .IDXW(3), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .idx     (idx),
        .enable  (enable),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit m_valid = 0;
    bit m_en    = 0;
    int m_idx   = 0;
    bit m_to    = 0;
    int m_last  = N - 1;   // requester served most recently
    int m_held  = 0;       // cycles the current grant has been visible

    // Grants observed on the DUT, recorded when enable rises.
    int grants[$];
    bit prev_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // The next winner is the first requester after the last one served.
    function automatic int pick(input int last, input logic [7:0] r);
        for (int o = 1; o <= N; o++) begin
            if (r[(last + o) % N]) return (last + o) % N;
        end
        return -1;
    endfunction

    // Drive one cycle, advance the model at the edge, then compare 1 ns later.
    task automatic cyc(input logic [7:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        if (rs) begin
            m_valid = 1; m_en = 0; m_idx = 0; m_to = 0; m_last = N - 1; m_held = 0;
        end else begin
            m_to = 0;
            if (!m_en) begin
                if (r != 8'h00) begin
                    m_idx  = pick(m_last, r);
                    m_en   = 1;
                    m_held = 1;
                end
            end else if (d) begin
                m_en   = 0;
                m_last = m_idx;
            end else if (m_held == TO) begin
                m_en   = 0;
                m_last = m_idx;
                m_to   = 1;
            end else begin
                m_held++;
            end
        end
        #1;
        if (m_valid) begin
            chk("enable", int'(enable), int'(m_en));
            chk("timeout", int'(timeout), int'(m_to));
            chk("idx", int'(idx), m_idx);
        end
        if (rs) prev_en = 0;
        if (enable === 1'b1 && !prev_en) begin
            grants.push_back(int'(idx));
            $display("grant idx=%0d req=%02h t=%0t", idx, r, $time);
        end
        prev_en = (enable === 1'b1);
    endtask

    // Idle with requests until a grant appears, bounded.
    task automatic wait_grant(input logic [7:0] r);
        for (int i = 0; i < 40; i++) begin
            cyc(r, 1'b0, 1'b0);
            if (enable === 1'b1) break;
        end
        chk("wait_grant", int'(enable === 1'b1), 1);
    endtask

    initial begin
        int seq2[4] = '{2, 5, 2, 5};
        int len;
        int dprob;

        // 1. Reset, then idle with no requests.
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(8'h00, 1'b0, 1'b0);
            chk("idle_enable", int'(enable), 0);
            chk("idle_idx", int'(idx), 0);
            chk("idle_timeout", int'(timeout), 0);
        end

        // 2. Two requesters; done two cycles into each grant.
        grants.delete();
        for (int g = 0; g < 4; g++) begin
            wait_grant(8'b0010_0100);
            cyc(8'b0010_0100, 1'b0, 1'b0);
            cyc(8'b0010_0100, 1'b1, 1'b0);
            chk("gap_enable_low", int'(enable), 0);
        end
        chk("seq2_count", grants.size(), 4);
        for (int g = 0; g < 4 && g < grants.size(); g++) chk("seq2_idx", grants[g], seq2[g]);

        // 3. All requesting; done on each grant cycle -> 0..7,0.
        cyc(8'h00, 1'b0, 1'b1);
        grants.delete();
        for (int g = 0; g < 9; g++) begin
            wait_grant(8'hFF);
            cyc(8'hFF, 1'b1, 1'b0);
        end
        chk("seq3_count", grants.size(), 9);
        for (int g = 0; g < 9 && g < grants.size(); g++) chk("seq3_idx", grants[g], g % N);

        // 4. Single requester and no done -> timeout after 16 enabled cycles.
        cyc(8'h00, 1'b0, 1'b1);
        wait_grant(8'h08);
        len = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(8'h08, 1'b0, 1'b0);
            if (enable !== 1'b1) break;
            len++;
        end
        chk("to_len", len, 16);
        chk("to_pulse", int'(timeout), 1);
        chk("to_idx", int'(idx), 3);
        cyc(8'h08, 1'b0, 1'b0);
        chk("to_regrant_en", int'(enable), 1);
        chk("to_regrant_idx", int'(idx), 3);
        chk("to_pulse_once", int'(timeout), 0);

        // 5. Reset mid-grant; pointer returns to 7.
        cyc(8'h88, 1'b0, 1'b1);
        chk("rst_enable", int'(enable), 0);
        chk("rst_idx", int'(idx), 0);
        wait_grant(8'h88);
        chk("rst_next_idx", int'(idx), 3);

        // 6. done in the same cycle as the timeout condition; then done while idle.
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        wait_grant(8'h40);
        for (int i = 0; i < 15; i++) cyc(8'h40, 1'b0, 1'b0);
        chk("race_still_held", int'(enable), 1);
        cyc(8'h40, 1'b1, 1'b0);
        chk("race_release", int'(enable), 0);
        chk("race_no_timeout", int'(timeout), 0);
        for (int i = 0; i < 3; i++) cyc(8'h00, 1'b1, 1'b0);
        chk("idle_done_enable", int'(enable), 0);
        wait_grant(8'h41);
        chk("idle_done_ptr", int'(idx), 0);

        // 7. Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] r;
            dprob = (i < 2000) ? 3 : 24;
            r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom() & $urandom());
            cyc(r, ($urandom_range(0, dprob) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
